// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: registered N-master arbiter in front of one shared memory port.
// Each transaction is latched into mem_* registers, held while memory is busy,
// and completes with a one-cycle done pulse plus registered read data.
// Build option: define MEM_ARB_FIXED_PRIO_EN for fixed priority (master 0
// highest, no round-robin pointer); left undefined, arbitration is round-robin.
`default_nettype none

module mem_arbiter_rr #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        req,
    input  logic [NUM_MASTERS*ADDR_W-1:0] addr,
    input  logic [NUM_MASTERS-1:0]        write,
    input  logic [NUM_MASTERS*DATA_W-1:0] wdata,
    output logic [NUM_MASTERS-1:0]        stall,
    output logic [NUM_MASTERS-1:0]        done,
    output logic [DATA_W-1:0]             rdata,
    output logic                          mem_valid,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_write,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic                          mem_ready,
    input  logic [DATA_W-1:0]             mem_rdata
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_MASTERS-1:0]  grant_q, grant_d;
    logic                    mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
    logic                    mem_write_q, mem_write_d;
    logic [DATA_W-1:0]       mem_wdata_q, mem_wdata_d;
    logic [NUM_MASTERS-1:0]  done_q, done_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;

    logic                    arb_found;
    logic [IDX_W-1:0]        arb_idx;

`ifdef MEM_ARB_FIXED_PRIO_EN
    // Fixed priority: scan from the top so the lowest requesting index is left last.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (req[k]) begin
                arb_found = 1'b1;
                arb_idx   = k[IDX_W-1:0];
            end
        end
    end
`else
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]        win_idx_q, win_idx_d;
    logic [IDX_W:0]          rr_sum;
    logic [IDX_W-1:0]        rr_cand;

    // Round-robin: walk rr_ptr, rr_ptr+1, ... (mod N); first requester found wins.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        rr_sum    = '0;
        rr_cand   = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            // rr_ptr < N and k < N, so a single conditional subtract wraps it.
            rr_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (rr_sum >= (IDX_W+1)'(NUM_MASTERS)) begin
                rr_sum = rr_sum - (IDX_W+1)'(NUM_MASTERS);
            end
            rr_cand = rr_sum[IDX_W-1:0];
            if (!arb_found && req[rr_cand]) begin
                arb_found = 1'b1;
                arb_idx   = rr_cand;
            end
        end
    end
`endif

    // Next-state and registered-output logic for the IDLE/BUSY handshake.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_write_d = mem_write_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = '0;
        rdata_d     = rdata_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
        rr_ptr_d    = rr_ptr_q;
        win_idx_d   = win_idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    grant_d          = '0;
                    grant_d[arb_idx] = 1'b1;
                    mem_valid_d      = 1'b1;
                    mem_addr_d       = addr[int'(arb_idx)*ADDR_W +: ADDR_W];
                    mem_write_d      = write[arb_idx];
                    mem_wdata_d      = wdata[int'(arb_idx)*DATA_W +: DATA_W];
`ifndef MEM_ARB_FIXED_PRIO_EN
                    win_idx_d        = arb_idx;
`endif
                    state_d          = BUSY;
                end
            end
            BUSY: begin
                // mem_* stay frozen until memory signals completion.
                if (mem_ready) begin
                    rdata_d     = mem_rdata;
                    done_d      = grant_q;
                    mem_valid_d = 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
                    rr_ptr_d    = (win_idx_q == IDX_W'(NUM_MASTERS - 1)) ? '0
                                                                        : win_idx_q + 1'b1;
`endif
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_write_q <= 1'b0;
            mem_wdata_q <= '0;
            done_q      <= '0;
            rdata_q     <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= '0;
            win_idx_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_write_q <= mem_write_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= rr_ptr_d;
            win_idx_q   <= win_idx_d;
`endif
        end
    end

    // A master is released in exactly the cycle its done pulse is visible.
    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_stall
            assign stall[gi] = req[gi] & ~done_q[gi];
        end
    endgenerate

    assign done      = done_q;
    assign rdata     = rdata_q;
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_write = mem_write_q;
    assign mem_wdata = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter_rr.sv
// Testbench for mem_arbiter_rr: directed scenarios with literal expectations,
// then randomized masters/memory checked every cycle against a transaction model.
`timescale 1ns/1ps

module tb_mem_arbiter_rr;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*AW-1:0] addr;
    logic [N-1:0]    write;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    stall;
    logic [N-1:0]    done;
    logic [DW-1:0]   rdata;
    logic            mem_valid;
    logic [AW-1:0]   mem_addr;
    logic            mem_write;
    logic [DW-1:0]   mem_wdata;
    logic            mem_ready;
    logic [DW-1:0]   mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter_rr #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .write(write), .wdata(wdata),
        .stall(stall), .done(done), .rdata(rdata), .mem_valid(mem_valid),
        .mem_addr(mem_addr), .mem_write(mem_write), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- transaction-level reference model ----------------
    bit            chk_en = 1'b0;
    bit            m_busy = 1'b0;
    int            m_win  = 0;
    int            m_ptr  = 0;
    logic          exp_valid;
    logic [AW-1:0] exp_addr;
    logic          exp_write;
    logic [DW-1:0] exp_wdata;
    logic [N-1:0]  exp_done = '0;
    logic [DW-1:0] exp_rdata;

    function automatic int arb_pick(input logic [N-1:0] r, input int ptr);
`ifdef MEM_ARB_FIXED_PRIO_EN
        for (int k = 0; k < N; k++) if (r[k]) return k;
`else
        for (int k = 0; k < N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
`endif
        return -1;
    endfunction

    always @(posedge clk) begin : model
        logic [N-1:0] dn;
        dn = '0;
        if (rst) begin
            m_busy = 1'b0; m_ptr = 0; m_win = 0;
            exp_valid = 1'b0; exp_addr = '0; exp_write = 1'b0; exp_wdata = '0;
            exp_rdata = '0;
            chk_en = 1'b1;
        end else if (!m_busy) begin
            if (req != '0) begin
                m_win     = arb_pick(req, m_ptr);
                exp_addr  = addr[m_win*AW +: AW];
                exp_write = write[m_win];
                exp_wdata = wdata[m_win*DW +: DW];
                exp_valid = 1'b1;
                m_busy    = 1'b1;
            end
        end else if (mem_ready) begin
            exp_rdata = mem_rdata;
            dn[m_win] = 1'b1;
            exp_valid = 1'b0;
            m_busy    = 1'b0;
            m_ptr     = (m_win + 1) % N;
        end
        exp_done = dn;
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("mem_valid", 64'(mem_valid), 64'(exp_valid));
            cmp("mem_addr",  64'(mem_addr),  64'(exp_addr));
            cmp("mem_write", 64'(mem_write), 64'(exp_write));
            cmp("mem_wdata", 64'(mem_wdata), 64'(exp_wdata));
            cmp("done",      64'(done),      64'(exp_done));
            cmp("rdata",     64'(rdata),     64'(exp_rdata));
            cmp("stall",     64'(stall),     64'(req & ~exp_done));
        end
    end

    // ---------------- stimulus ----------------
    int rr_order[5];
    int two_order[4];

    initial begin
        rst = 1'b1; req = '0; addr = '0; write = '0; wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;

        // Reset / idle
        tick; tick;
        rst = 1'b0;
        cmp("rst_valid", 64'(mem_valid), 64'(0));
        cmp("rst_addr",  64'(mem_addr),  64'(0));
        cmp("rst_write", 64'(mem_write), 64'(0));
        cmp("rst_wdata", 64'(mem_wdata), 64'(0));
        cmp("rst_done",  64'(done),      64'(0));
        cmp("rst_stall", 64'(stall),     64'(0));
        cmp("rst_rdata", 64'(rdata),     64'(0));
        tick;
        cmp("idle_valid", 64'(mem_valid), 64'(0));
        $display("txn reset/idle checked");

        // Single read from master 0, memory ready on the 2nd BUSY cycle
        req = 4'b0001; addr[0 +: AW] = 32'h1000; write = '0;
        tick;
        cmp("rd_valid",  64'(mem_valid), 64'(1));
        cmp("rd_addr",   64'(mem_addr),  64'(32'h1000));
        cmp("rd_stall1", 64'(stall[0]),  64'(1));
        tick;
        cmp("rd_stall2", 64'(stall[0]),  64'(1));
        cmp("rd_nodone", 64'(done),      64'(0));
        mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick;
        cmp("rd_done",   64'(done),      64'(4'b0001));
        cmp("rd_rdata",  64'(rdata),     64'(32'hDEADBEEF));
        cmp("rd_unstall",64'(stall[0]),  64'(0));
        req = '0; mem_ready = 1'b0;
        tick;
        cmp("rd_pulse",  64'(done),      64'(0));
        $display("txn single read m0 addr=1000 rdata=%0h", rdata);

        // Write from master 1, held for 5 not-ready cycles
        req = 4'b0010; write = 4'b0010;
        addr[AW +: AW] = 32'h2000; wdata[DW +: DW] = 32'h55;
        tick;
        for (int k = 0; k < 5; k++) begin
            cmp("wr_write", 64'(mem_write), 64'(1));
            cmp("wr_addr",  64'(mem_addr),  64'(32'h2000));
            cmp("wr_wdata", 64'(mem_wdata), 64'(32'h55));
            cmp("wr_valid", 64'(mem_valid), 64'(1));
            tick;
        end
        mem_ready = 1'b1;
        tick;
        cmp("wr_done", 64'(done), 64'(4'b0010));
        req = '0; write = '0; mem_ready = 1'b0;
        tick;
        $display("txn write m1 addr=2000 wdata=55");

        // Mid-operation reset, then contention from a fresh pointer
        for (int i = 0; i < N; i++) addr[i*AW +: AW] = 32'h100 * (i + 1);
        req = 4'b1111;
        tick;
`ifdef MEM_ARB_FIXED_PRIO_EN
        cmp("mid_grant", 64'(mem_addr), 64'(32'h100));
`else
        cmp("mid_grant", 64'(mem_addr), 64'(32'h300));
`endif
        tick;
        rst = 1'b1;
        tick;
        cmp("mid_rst_valid", 64'(mem_valid), 64'(0));
        cmp("mid_rst_done",  64'(done),      64'(0));
        rst = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hA5A5;
        tick;
        cmp("post_rst_grant", 64'(mem_addr),  64'(32'h100));
        cmp("post_rst_valid", 64'(mem_valid), 64'(1));
        cmp("post_rst_nodone",64'(done),      64'(0));
        $display("txn mid-op reset, regrant m0");

`ifdef MEM_ARB_FIXED_PRIO_EN
        rr_order  = '{0, 0, 0, 0, 0};
        two_order = '{1, 1, 1, 1};
`else
        rr_order  = '{0, 1, 2, 3, 0};
        two_order = '{1, 2, 1, 2};
`endif
        for (int t = 0; t < 5; t++) begin
            tick;
            cmp("contend_done", 64'(done), 64'(1) << rr_order[t]);
            $display("txn contention done=%b", done);
            if (t == 4) req = '0;
            tick;
        end
        mem_ready = 1'b0;
        tick;

        // Two requesters: alternate under round-robin, master 1 starves master 2 under fixed priority
        req = 4'b0110; mem_ready = 1'b1;
        tick;
        for (int t = 0; t < 4; t++) begin
            tick;
            cmp("pair_done", 64'(done), 64'(1) << two_order[t]);
`ifdef MEM_ARB_FIXED_PRIO_EN
            cmp("pair_stall2", 64'(stall[2]), 64'(1));
`endif
            $display("txn pair done=%b", done);
            if (t == 3) req = '0;
            tick;
        end
        mem_ready = 1'b0;
        tick;

        // Randomized masters and memory
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] || exp_done[i]) begin
                    req[i]              = ($urandom_range(0, 99) < 50);
                    addr[i*AW +: AW]    = $urandom;
                    write[i]            = 1'($urandom_range(0, 1));
                    wdata[i*DW +: DW]   = $urandom;
                end
            end
            mem_ready = ($urandom_range(0, 99) < 40);
            mem_rdata = $urandom;
            rst       = ($urandom_range(0, 199) == 0);
            if (exp_done != '0) $display("txn random done=%b rdata=%0h", exp_done, exp_rdata);
            tick;
        end
        rst = 1'b0; req = '0; mem_ready = 1'b0;
        tick; tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
